remap_packer: RTL and testbench

- Downstream stage of the piecewise-linear remapper.
- Consumes one remapped `M2_LENGTH`-bit sample per handshake and packs consecutive samples LSB-first into fixed-width output words for the memory/stream interface.
- Provides a valid/ready output with back-pressure, a flush mechanism that emits a zero-padded partial word, and word/sample counters for status readout.

---
 rtl/remap_packer_pkg.sv | 28 ++
 rtl/remap_packer_ctl.sv | 53 +++++
 rtl/remap_packer.sv | 99 +++++++++
 tb/tb_remap_packer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/remap_packer_pkg.sv
// Shared defaults and helpers for the remap packer: sample/word/counter widths,
// the flush control state type and a ceiling-log2 helper for port widths.
`ifndef M2_LENGTH
`define M2_LENGTH 12
`endif

package remap_packer_pkg;

    localparam int M2_LENGTH = `M2_LENGTH;
    localparam int OUT_W_DEF = 32;
    localparam int CNT_W_DEF = 16;

    typedef enum logic {
        FL_IDLE = 1'b0,
        FL_PEND = 1'b1
    } flush_state_t;

    // Smallest r with 2**r >= v; evaluated at elaboration for port widths.
    function automatic int clog2_ceil(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/remap_packer_ctl.sv
// Flush and output-slot control for the packer: gates input acceptance and
// decides the cycle on which a requested flush completes.
module remap_packer_ctl
    import remap_packer_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic out_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic flush_fire,
    output logic flush_done
);

    // state   | meaning
    // FL_IDLE | no flush outstanding; samples accepted whenever the slot is free
    // FL_PEND | flush requested; input stalled until the output slot frees

    flush_state_t state, state_next;
    logic         slot_free;

    always_comb begin
        slot_free  = !out_valid || out_ready;
        state_next = state;
        in_ready   = 1'b0;
        flush_fire = 1'b0;
        unique case (state)
            FL_IDLE: begin
                in_ready = slot_free;
                if (flush) state_next = FL_PEND;
            end
            FL_PEND: begin
                // A repeated flush here is absorbed by the one already pending.
                if (slot_free) begin
                    flush_fire = 1'b1;
                    state_next = FL_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FL_IDLE;
            flush_done <= 1'b0;
        end else begin
            state      <= state_next;
            flush_done <= flush_fire;
        end
    end

endmodule

// File: rtl/remap_packer.sv
// Packs remapped samples LSB-first into OUT_W-bit words with valid/ready output,
// zero-padded flush of the partial word and saturating status counters.
module remap_packer
    import remap_packer_pkg::*;
#(
    parameter int IN_W  = M2_LENGTH,
    parameter int OUT_W = OUT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [IN_W-1:0]                    in_data,
    input  logic                               flush,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [OUT_W-1:0]                   out_word,
    output logic [clog2_ceil(OUT_W+1)-1:0]     out_bits,
    output logic                               out_last,
    output logic                               flush_done,
    output logic [CNT_W-1:0]                   word_cnt,
    output logic [CNT_W-1:0]                   sample_cnt
);

    localparam int BITS_W = clog2_ceil(OUT_W + 1);
    localparam int SUM_W  = BITS_W + 1;

    logic [OUT_W-1:0]   res;
    logic [BITS_W-1:0]  fill;
    logic [SUM_W-1:0]   sum;
    logic [2*OUT_W-1:0] merged;
    logic               accept;
    logic               full;
    logic               flush_fire;
    logic               load_part;

    remap_packer_ctl u_ctl (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .in_ready   (in_ready),
        .flush_fire (flush_fire),
        .flush_done (flush_done)
    );

    // Double-width merge: low half is the candidate word, high half the carry-over.
    assign merged    = {{OUT_W{1'b0}}, res} | ({{(2*OUT_W-IN_W){1'b0}}, in_data} << fill);
    assign sum       = {1'b0, fill} + SUM_W'(IN_W);
    assign full      = sum >= SUM_W'(OUT_W);
    assign accept    = in_valid && in_ready;
    assign load_part = flush_fire && (fill != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res       <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_bits  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (accept && full) begin
                out_word  <= merged[OUT_W-1:0];
                out_bits  <= BITS_W'(OUT_W);
                out_last  <= 1'b0;
                out_valid <= 1'b1;
                res       <= merged[2*OUT_W-1:OUT_W];
                fill      <= BITS_W'(sum - SUM_W'(OUT_W));
            end else if (accept) begin
                res  <= merged[OUT_W-1:0];
                fill <= sum[BITS_W-1:0];
                if (out_ready) out_valid <= 1'b0;
            end else if (load_part) begin
                out_word  <= res;
                out_bits  <= fill;
                out_last  <= 1'b1;
                out_valid <= 1'b1;
                res       <= '0;
                fill      <= '0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            word_cnt   <= '0;
        end else begin
            if (accept && (sample_cnt != '1)) sample_cnt <= sample_cnt + CNT_W'(1);
            if (out_valid && out_ready && (word_cnt != '1)) word_cnt <= word_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_remap_packer.sv
// Bench for remap_packer: two instances (7-bit samples with 4-bit counters, 8-bit
// samples with 16-bit counters) against a bit-stream model plus literal checks.
module tb_remap_packer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_out_last, a_flush_done;
    logic [6:0]  a_in_data;
    logic [15:0] a_out_word;
    logic [4:0]  a_out_bits;
    logic [3:0]  a_word_cnt, a_sample_cnt;

    logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_out_last, b_flush_done;
    logic [7:0]  b_in_data;
    logic [15:0] b_out_word;
    logic [4:0]  b_out_bits;
    logic [15:0] b_word_cnt, b_sample_cnt;

    remap_packer #(.IN_W(7), .OUT_W(16), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .flush(a_flush), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_word(a_out_word), .out_bits(a_out_bits), .out_last(a_out_last),
        .flush_done(a_flush_done), .word_cnt(a_word_cnt), .sample_cnt(a_sample_cnt));

    remap_packer #(.IN_W(8), .OUT_W(16), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_word(b_out_word), .out_bits(b_out_bits), .out_last(b_out_last),
        .flush_done(b_flush_done), .word_cnt(b_word_cnt), .sample_cnt(b_sample_cnt));

    int checks = 0;
    int failures = 0;
    int a_done_cnt = 0;

    // Model: an unbounded bit accumulator per instance and a queue of expected words {last,bits,word}.
    longint unsigned acc [2];
    int              nb [2];
    int              scnt [2];
    int              wcnt [2];
    logic [21:0]     qa [$];
    logic [21:0]     qb [$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int in_w(input int id);
        return (id == 0) ? 7 : 8;
    endfunction

    function automatic int cnt_max(input int id);
        return (id == 0) ? 15 : 65535;
    endfunction

    function automatic void push_exp(input int id, input logic [21:0] v);
        if (id == 0) qa.push_back(v);
        else qb.push_back(v);
    endfunction

    task automatic observe(input int id, input logic rst, input logic iv, input logic ir,
                           input logic [7:0] d, input logic fl, input logic ov, input logic ordy,
                           input logic [15:0] w, input logic [4:0] b, input logic l,
                           input int wc, input int sc);
        logic [21:0] e;
        int          qsize;
        if (!rst) begin
            acc[id] = 0; nb[id] = 0; scnt[id] = 0; wcnt[id] = 0;
            if (id == 0) qa.delete();
            else qb.delete();
            return;
        end
        chk($sformatf("dut%0d sample_cnt", id), sc, scnt[id]);
        chk($sformatf("dut%0d word_cnt", id), wc, wcnt[id]);
        if (ov && ordy) begin
            qsize = (id == 0) ? qa.size() : qb.size();
            if (qsize == 0) begin
                checks++;
                failures++;
                $display("FAIL dut%0d unexpected word: got 0x%0h expected none", id, w);
            end else begin
                e = (id == 0) ? qa.pop_front() : qb.pop_front();
                chk($sformatf("dut%0d out_word", id), w, e[15:0]);
                chk($sformatf("dut%0d out_bits", id), b, e[20:16]);
                chk($sformatf("dut%0d out_last", id), l, e[21]);
            end
            if (wcnt[id] < cnt_max(id)) wcnt[id]++;
        end
        if (iv && ir) begin
            acc[id] = acc[id] | (64'(d) << nb[id]);
            nb[id] += in_w(id);
            while (nb[id] >= 16) begin
                push_exp(id, {1'b0, 5'd16, acc[id][15:0]});
                acc[id] = acc[id] >> 16;
                nb[id] -= 16;
            end
            if (scnt[id] < cnt_max(id)) scnt[id]++;
        end
        // Input is stalled while a flush is pending, so the whole remainder belongs to this flush.
        if (fl && nb[id] > 0) begin
            push_exp(id, {1'b1, 5'(nb[id]), acc[id][15:0]});
            acc[id] = 0;
            nb[id] = 0;
        end
    endtask

    always @(negedge clk) begin
        observe(0, rst_n, a_in_valid, a_in_ready, {1'b0, a_in_data}, a_flush, a_out_valid,
                a_out_ready, a_out_word, a_out_bits, a_out_last, int'(a_word_cnt), int'(a_sample_cnt));
        observe(1, rst_n, b_in_valid, b_in_ready, b_in_data, b_flush, b_out_valid,
                b_out_ready, b_out_word, b_out_bits, b_out_last, int'(b_word_cnt), int'(b_sample_cnt));
        if (rst_n && a_flush_done) a_done_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [6:0] d, input logic fl);
        int n;
        n = 0;
        a_in_valid = 1'b1; a_in_data = d; a_flush = fl;
        @(negedge clk);
        while (!a_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!a_in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_a timeout: in_ready=0 required 1");
        end
        @(posedge clk);
        #1;
        a_in_valid = 1'b0; a_flush = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d);
        int n;
        n = 0;
        b_in_valid = 1'b1; b_in_data = d;
        @(negedge clk);
        while (!b_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!b_in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_b timeout: in_ready=0 required 1");
        end
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        a_in_valid = 0; a_in_data = 0; a_flush = 0; a_out_ready = 1;
        b_in_valid = 0; b_in_data = 0; b_flush = 0; b_out_ready = 1;

        cyc(2);
        chk("reset a out_valid", a_out_valid, 0);
        chk("reset a out_word", a_out_word, 0);
        chk("reset a word_cnt", a_word_cnt, 0);
        chk("reset a sample_cnt", a_sample_cnt, 0);
        chk("reset a flush_done", a_flush_done, 0);
        #1 rst_n = 1'b1;
        cyc(1);
        chk("idle a in_ready", a_in_ready, 1);
        chk("idle b in_ready", b_in_ready, 1);

        // 0x7F,0x00,0x55 -> 0x407F, residue 0x15 in 5 bits
        send_a(7'h7F, 0); send_a(7'h00, 0); send_a(7'h55, 0);
        chk("word1 valid", a_out_valid, 1);
        chk("word1 value", a_out_word, 16'h407F);
        chk("word1 bits", a_out_bits, 16);
        chk("word1 last", a_out_last, 0);

        a_flush = 1'b1;
        cyc(1);
        a_flush = 1'b0;
        chk("flush pending in_ready", a_in_ready, 0);
        chk("flush pending out_valid", a_out_valid, 0);
        cyc(1);
        chk("partial valid", a_out_valid, 1);
        chk("partial value", a_out_word, 16'h0015);
        chk("partial bits", a_out_bits, 5);
        chk("partial last", a_out_last, 1);
        chk("partial flush_done", a_flush_done, 1);
        chk("after flush in_ready", a_in_ready, 1);
        cyc(1);
        chk("flush_done one cycle", a_flush_done, 0);
        chk("partial handed off", a_out_valid, 0);

        // Flush with nothing buffered: done pulse only
        a_flush = 1'b1;
        cyc(1);
        a_flush = 1'b0;
        cyc(1);
        chk("empty flush done", a_flush_done, 1);
        chk("empty flush no word", a_out_valid, 0);

        // Flush held two cycles: the second request is absorbed
        send_a(7'h2A, 0);
        d0 = a_done_cnt;
        a_flush = 1'b1;
        cyc(2);
        a_flush = 1'b0;
        cyc(3);
        chk("held flush single done", a_done_cnt - d0, 1);

        // Sample with flush completing a word: full word then 5-bit partial
        send_a(7'h11, 0); send_a(7'h22, 0); send_a(7'h7F, 1);
        chk("flush+word value", a_out_word, 16'hD111);
        chk("flush+word bits", a_out_bits, 16);
        chk("flush+word last", a_out_last, 0);
        chk("flush+word in_ready", a_in_ready, 0);
        cyc(1);
        chk("flush+word partial", a_out_word, 16'h001F);
        chk("flush+word pbits", a_out_bits, 5);
        chk("flush+word plast", a_out_last, 1);
        chk("flush+word done", a_flush_done, 1);
        cyc(1);

        // Back-pressure on the 8-bit instance
        b_out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 6; i++) send_b(8'(i));
            end
            begin
                cyc(6);
                for (int k = 0; k < 3; k++) begin
                    chk("bp held valid", b_out_valid, 1);
                    chk("bp held word", b_out_word, 16'h0201);
                    chk("bp held bits", b_out_bits, 16);
                    chk("bp in_ready", b_in_ready, 0);
                    cyc(1);
                end
                b_out_ready = 1'b1;
            end
        join
        cyc(3);
        chk("bp word_cnt", b_word_cnt, 3);
        chk("bp sample_cnt", b_sample_cnt, 6);

        // Counter saturation on the 4-bit counters
        for (int i = 0; i < 40; i++) send_a(7'(i * 37 + 3), 0);
        cyc(2);
        chk("sat sample_cnt", a_sample_cnt, 15);
        chk("sat word_cnt", a_word_cnt, 15);

        // Asynchronous reset with a held word and residue
        a_out_ready = 1'b0;
        send_a(7'h7F, 0); send_a(7'h7F, 0);
        chk("pre-reset held", a_out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset out_valid", a_out_valid, 0);
        chk("async reset word_cnt", a_word_cnt, 0);
        chk("async reset sample_cnt", a_sample_cnt, 0);
        chk("async reset b sample_cnt", b_sample_cnt, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc(1);
        a_out_ready = 1'b1;
        send_a(7'h05, 1);
        cyc(1);
        chk("post-reset value", a_out_word, 16'h0005);
        chk("post-reset bits", a_out_bits, 7);
        chk("post-reset last", a_out_last, 1);
        chk("post-reset sample_cnt", a_sample_cnt, 1);
        cyc(3);

        chk("a words outstanding", qa.size(), 0);
        chk("b words outstanding", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
